// File: rtl/checkdigit_arbiter_if.sv
// Request/grant/result bundle between two digit requesters and the check-digit arbiter.
// The master side drives requests and digits; the slave (arbiter) returns grants and results.
interface checkdigit_arbiter_if;
  logic       req_a;
  logic [3:0] num_a;
  logic       req_b;
  logic [3:0] num_b;
  logic       gnt_a;
  logic       gnt_b;
  logic       out_valid;
  logic [3:0] out;
  logic       out_id;

  modport master (
    output req_a, num_a, req_b, num_b,
    input  gnt_a, gnt_b, out_valid, out, out_id
  );

  modport slave (
    input  req_a, num_a, req_b, num_b,
    output gnt_a, gnt_b, out_valid, out, out_id
  );
endinterface

// File: rtl/checkdigit_arbiter.sv
// Round-robin arbiter that lends one weighted-sum accumulator to two requesters
// and returns a 15-digit check digit (sum mod 10, with 0 reported as 15).
module checkdigit_arbiter (
  input  logic                   clk,
  input  logic                   rst_n,
  checkdigit_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_e;

  localparam logic [3:0] LAST_DIGIT = 4'd14;

  state_e     state_q, state_d;
  logic       owner_q, owner_d;     // 0 = A, 1 = B
  logic       ptr_q,   ptr_d;       // round-robin winner when both request
  logic [3:0] cnt_q,   cnt_d;
  logic [8:0] acc_q,   acc_d;
  logic       gnt_a_q, gnt_a_d;
  logic       gnt_b_q, gnt_b_d;
  logic       out_valid_q, out_valid_d;
  logic [3:0] out_q,   out_d;
  logic       out_id_q, out_id_d;

  logic       cur_req;
  logic [3:0] cur_num;
  logic [8:0] weighted;
  logic [8:0] sum_next;
  logic [3:0] rem;

  // Only the owner's lines matter; the other requester is ignored until the job ends.
  assign cur_req  = owner_q ? bus.req_b : bus.req_a;
  assign cur_num  = owner_q ? bus.num_b : bus.num_a;
  assign weighted = cnt_q[0] ? {5'd0, cur_num} : {4'd0, cur_num, 1'b0};
  assign sum_next = acc_q + weighted;
  assign rem      = 4'(sum_next % 9'd10);

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    gnt_a_d     = 1'b0;
    gnt_b_d     = 1'b0;
    out_valid_d = 1'b0;
    out_d       = 4'd0;
    out_id_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req_a || bus.req_b) begin
          owner_d = (bus.req_a && bus.req_b) ? ptr_q : bus.req_b;
          state_d = GRANT;
          cnt_d   = 4'd0;
          acc_d   = 9'd0;
          gnt_a_d = ~owner_d;
          gnt_b_d = owner_d;
        end
      end

      GRANT: begin
        if (!cur_req) begin
          // Owner withdrew: drop the digit on the bus and give the other side priority.
          state_d = IDLE;
          ptr_d   = ~owner_q;
        end else begin
          acc_d = sum_next;
          if (cnt_q == LAST_DIGIT) begin
            state_d     = DONE;
            ptr_d       = ~owner_q;
            out_valid_d = 1'b1;
            out_d       = (rem == 4'd0) ? 4'd15 : rem;
            out_id_d    = owner_q;
          end else begin
            cnt_d   = cnt_q + 4'd1;
            gnt_a_d = ~owner_q;
            gnt_b_d = owner_q;
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      ptr_q       <= 1'b0;
      cnt_q       <= 4'd0;
      acc_q       <= 9'd0;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= 4'd0;
      out_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      gnt_a_q     <= gnt_a_d;
      gnt_b_q     <= gnt_b_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      out_id_q    <= out_id_d;
    end
  end

  assign bus.gnt_a     = gnt_a_q;
  assign bus.gnt_b     = gnt_b_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.out_id    = out_id_q;

endmodule

// File: doc/checkdigit_arbiter.md
CHECKDIGIT_ARBITER -- requirements
Module: checkdigit_arbiter

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port req_a  input  1  requester A wants a 15-digit check-digit job; held high until job ends.
REQ-004 SHALL have port num_a  input  4  requester A digit, sampled only on cycles where gnt_a=1.
REQ-005 SHALL have port req_b  input  1  requester B request; same rules as req_a.
REQ-006 SHALL have port num_b  input  4  requester B digit, sampled only on cycles where gnt_b=1.
REQ-007 SHALL have port gnt_a  output  1  registered; high during each of the 15 digit cycles of an A job.
REQ-008 SHALL have port gnt_b  output  1  registered; high during each of the 15 digit cycles of a B job.
REQ-009 SHALL have port out_valid  output  1  registered; one-cycle pulse when a check digit is ready.
REQ-010 SHALL have port out  output  4  check digit; 0 whenever out_valid=0.
REQ-011 SHALL have port out_id  output  1  owner of result (0=A, 1=B); 0 whenever out_valid=0.

Function
REQ-012 SHALL implement FSM states IDLE, GRANT, DONE; exactly one accumulator shared by both requesters.
REQ-013 In IDLE with neither req high SHALL stay in IDLE with gnt_a=gnt_b=0.
REQ-014 In IDLE with one req high SHALL go to GRANT for that requester; its gnt rises in the next cycle.
REQ-015 In IDLE with both req high SHALL grant the requester indicated by a round-robin priority pointer.
REQ-016 Priority pointer SHALL reset to A and SHALL point to the other requester after every job, whether completed or aborted.
REQ-017 In GRANT, exactly one gnt SHALL be high; a 4-bit digit counter SHALL run 0..14, one digit sampled per cycle.
REQ-018 Digit at counter value k SHALL add 2*num when k is even and num when k is odd; digits 10..15 are accepted unchanged.
REQ-019 Accumulator SHALL be 9 bits (max 8*30+7*15=345) and SHALL clear when a new GRANT begins.
REQ-020 After the sample at counter 14, SHALL enter DONE; gnt SHALL drop in that same cycle.
REQ-021 In DONE, out_valid=1 for exactly one cycle; out = sum mod 10, except out=15 when sum mod 10 = 0; out_id = served requester.
REQ-022 DONE SHALL always return to IDLE, giving at least one idle cycle between jobs; first-digit-to-out_valid latency = 15 cycles.
REQ-023 If the granted requester drops req during GRANT, SHALL abort at that edge: discard the digit, drop gnt, go to IDLE, no out_valid.
REQ-024 The non-granted requester's req/num SHALL have no effect during GRANT or DONE; its request stays pending.

Reset
REQ-025 On rst_n=0, SHALL immediately go to IDLE, clear counter, accumulator and pointer (A), and drive gnt_a=gnt_b=out_valid=out_id=0, out=0.
REQ-026 Reset mid-job SHALL discard the partial job; no out_valid SHALL follow release of reset.
REQ-027 First grant after reset release SHALL require req high in IDLE on a clock edge with rst_n=1.

Verification
REQ-028 A alone, 15 digits all 1 -> gnt_a high 15 cycles; out_valid once, out=3 (sum 23), out_id=0.
REQ-029 B alone, 15 digits all 0 -> out=15 (sum 0), out_id=1.
REQ-030 A alone, 15 digits all 15 -> sum 345, out=5; no accumulator overflow.
REQ-031 req_a and req_b both high from reset release -> A served first (out_id=0), then B after one IDLE cycle (out_id=1), then A again if still requesting.
REQ-032 req_a dropped after 7 granted digits while req_b high -> no out_valid for A; B granted next with a cleared accumulator, correct B result.
REQ-033 rst_n pulsed low at digit 10 of a job -> all outputs 0 immediately; no out_valid afterward; next job correct from a clean start.
